matrix_uart_printer: RTL and testbench
======================================

# matrix_uart_printer

- Parametrised matrix-to-UART text formatter; sits between matrix storage and the UART transmitter.
- On a start pulse it snapshots an up-to-MAX_DIM×MAX_DIM matrix and prints it row-major as multi-digit decimal ASCII.
- Elements are space-separated; each row ends with CR LF.
- Successor to the single-digit displayer: arbitrary element width, configurable maximum dimension, leading-zero-suppressed decimal, dimension error reporting, explicit done pulse.

## Interface
Parameters:
- DATA_W, 8, element width in bits (4..16)
- MAX_DIM, 5, maximum rows/columns (1..7)
- DIM_W, 3, width of row/col inputs; must satisfy 2^DIM_W > MAX_DIM

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  level/pulse; sampled only in IDLE
- row, col  in  DIM_W  matrix dimensions, sampled with start
- data_flat  in  MAX_DIM*MAX_DIM*DATA_W  element k = r*col+c at bits [k*DATA_W +: DATA_W]
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after the last LF is accepted by UART
- err  out  1  one-cycle pulse on rejected start
- tx_data  out  8  byte to UART
- tx_start  out  1  one-cycle byte strobe
- tx_busy  in  1  UART busy

## Operation
- Reset: all outputs 0 (busy, done, err, tx_start, tx_data=8'h00); state IDLE; counters 0.
- Reset mid-print aborts immediately. tx_start is never asserted in the cycle after rst. A partial line is not completed.
- IDLE, start=1:
  - If row==0, col==0, row>MAX_DIM or col>MAX_DIM: pulse err next cycle and stay IDLE.
  - Otherwise snapshot data_flat, row and col on the same edge, set r=c=0, go to CONV.
- start while busy: ignored.
- After DONE, a new start is accepted only after start is seen low at least once (WAIT_RELEASE).
- CONV: sequential double-dabble of element k into BCD. Takes exactly DATA_W cycles, then goes to EMIT.
- EMIT: sends BCD digits MSB-first.
  - Leading zeros are suppressed.
  - Value 0 prints "0".
  - Each digit is 8'h30+digit.
- SEP: after each element:
  - c<col-1: send 8'h20, then c++ and go to CONV.
  - otherwise: send 8'h0D, then 8'h0A, then c=0.
  - After the row break: if r==row-1 go to DONE, else r++ and go to CONV.
- DONE: busy=0 and done=1 for one cycle, then go to WAIT_RELEASE.
- Arithmetic: index uses snapshotted col with DIM_W×DIM_W multiply, truncated to the index width. Out-of-range indices cannot occur after the validity check.

## Timing
Byte handshake (every byte uses the same SEND/GUARD/WAIT sequence):
- SEND: when tx_busy==0 in cycle N, drive tx_data and tx_start=1 for cycle N only.
- GUARD: cycle N+1 ignores tx_busy, for UARTs that raise busy one cycle late.
- WAIT: from N+2, hold until tx_busy==0, then move to the next byte's SEND in the following cycle.
- If tx_busy==1 in SEND, hold tx_start=0 and tx_data stable.

Latencies:
- start accepted at edge E0 → busy=1 after E0.
- First tx_start occurs DATA_W+1 cycles after E0 when tx_busy is idle.
- done is asserted in the cycle after the final LF's WAIT completes; busy falls in that same cycle.

Throughput:
- Conversion of element k+1 does not overlap with the UART sending element k.

## Configuration
- MATRIX_PRINTER_SIGNED_EN defined:
  - Elements are two's complement.
  - Negative values emit 8'h2D ('-') first, then the magnitude.
  - The magnitude is computed in one extra cycle before CONV.
  - -2^(DATA_W-1) prints correctly; e.g. DATA_W=8, 8'h80 → "-128".
- Not defined: elements are unsigned, no '-' path, and CONV starts with no extra cycle.

## Test plan
- 2×3, values 1,2,3,10,200,0; UART model busy 10 cycles per byte → exact byte stream "1 2 3\r\n10 200 0\r\n", then one done pulse and busy low.
- row=0, col=3 start → err pulse one cycle later; no tx_start within 50 cycles; busy stays 0.
- row=6 with MAX_DIM=5 → err pulse, no tx_start.
- Element 8'hFF, 1×1, macro defined → "-1\r\n"; macro undefined → "255\r\n". Also 8'h80 defined → "-128\r\n".
- tx_busy held high 100 cycles after the first byte → no second tx_start until it drops. tx_busy delayed one cycle after tx_start → no byte duplicated or lost.
- rst pulsed while printing the second row → next cycle all outputs 0. A fresh start (after start low) of a 1×1 value 7 prints exactly "7\r\n". Start toggled during busy → ignored.

Source files
------------

// File: rtl/matrix_uart_printer_if.sv
// Bundle between the matrix printer, the matrix storage and the UART transmitter.
interface matrix_uart_printer_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_DIM = 5,
    parameter int unsigned DIM_W   = 3
);
    logic                                start;
    logic [DIM_W-1:0]                    row;
    logic [DIM_W-1:0]                    col;
    logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   data_flat;
    logic                                busy;
    logic                                done;
    logic                                err;
    logic [7:0]                          tx_data;
    logic                                tx_start;
    logic                                tx_busy;

    // Printer side
    modport master (
        input  start, row, col, data_flat, tx_busy,
        output busy, done, err, tx_data, tx_start
    );

    // Storage / UART side
    modport slave (
        output start, row, col, data_flat, tx_busy,
        input  busy, done, err, tx_data, tx_start
    );
endinterface

// File: rtl/matrix_uart_printer.sv
// Matrix-to-UART decimal text formatter.
// Snapshots a row x col matrix on start and prints it row-major as
// leading-zero-suppressed decimal ASCII, space separated, CR LF per row.
// Optional feature macro: MATRIX_PRINTER_SIGNED_EN (two's complement elements,
// '-' prefix, one extra magnitude cycle before conversion).
module matrix_uart_printer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_DIM = 5,
    parameter int unsigned DIM_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_uart_printer_if.master bus
);
    localparam int unsigned N_ELEM = MAX_DIM * MAX_DIM;
    localparam int unsigned IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned PROD_W = 2 * DIM_W;
    localparam int unsigned N_DIG  = (DATA_W * 30103) / 100000 + 1;
    localparam int unsigned BCD_W  = 4 * N_DIG;
    localparam int unsigned DIG_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int unsigned CNT_W  = $clog2(DATA_W);

    typedef enum logic [3:0] {
        S_IDLE, S_NEG, S_CONV, S_MINUS, S_EMIT, S_SEP, S_LF, S_DONE, S_WAIT_REL
    } state_t;

    typedef enum logic [1:0] {H_SEND, H_STROBE, H_GUARD, H_WAIT} hs_t;

`ifdef MATRIX_PRINTER_SIGNED_EN
    localparam state_t CONV_ENTRY = S_NEG;
`else
    localparam state_t CONV_ENTRY = S_CONV;
`endif

    state_t               state_q;
    hs_t                  hs_q;
    logic [DATA_W-1:0]    elem_q [N_ELEM];
    logic [DIM_W-1:0]     row_q, col_q, r_q, c_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [DIG_W-1:0]     dig_q;
    logic                 busy_q, done_q, err_q, tx_start_q;
    logic [7:0]           tx_data_q;
`ifdef MATRIX_PRINTER_SIGNED_EN
    logic [DATA_W-1:0]    mag_q;
    logic                 neg_q;
`endif

    logic [PROD_W-1:0]    prod_c;
    logic [IDX_W-1:0]     idx_c;
    logic [DATA_W-1:0]    elem_c;
    logic [DATA_W-1:0]    src_c;
    logic                 in_bit_c;
    logic [BCD_W-1:0]     bcd_adj_c;
    logic [BCD_W-1:0]     bcd_nxt_c;
    logic [DIG_W-1:0]     lead_c;
    logic [3:0]           digit_c;
    logic                 last_col_c, last_row_c, bad_dim_c;
    logic [7:0]           byte_c;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;

    // Element fetch, double-dabble step, leading-digit search and byte selection
    always_comb begin
        prod_c = PROD_W'(r_q) * PROD_W'(col_q);
        idx_c  = IDX_W'(prod_c) + IDX_W'(c_q);
        elem_c = elem_q[idx_c];
`ifdef MATRIX_PRINTER_SIGNED_EN
        src_c  = mag_q;
`else
        src_c  = elem_c;
`endif
        in_bit_c = src_c[CNT_W'(DATA_W - 1) - cnt_q];

        bcd_adj_c = bcd_q;
        for (int i = 0; i < int'(N_DIG); i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj_c[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bcd_nxt_c = BCD_W'({bcd_adj_c, in_bit_c});

        lead_c = '0;
        for (int i = 0; i < int'(N_DIG); i++) begin
            if (bcd_nxt_c[i*4 +: 4] != 4'd0) begin
                lead_c = DIG_W'(i);
            end
        end

        digit_c    = 4'(bcd_q >> {dig_q, 2'b00});
        last_col_c = (c_q == col_q - DIM_W'(1));
        last_row_c = (r_q == row_q - DIM_W'(1));
        bad_dim_c  = (bus.row == '0) || (bus.col == '0) ||
                     (bus.row > DIM_W'(MAX_DIM)) || (bus.col > DIM_W'(MAX_DIM));

        case (state_q)
            S_MINUS: byte_c = 8'h2D;
            S_EMIT:  byte_c = 8'h30 | {4'h0, digit_c};
            S_SEP:   byte_c = last_col_c ? 8'h0D : 8'h20;
            S_LF:    byte_c = 8'h0A;
            default: byte_c = 8'h00;
        endcase
    end

    // Control FSM with byte handshake sub-phase; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hs_q       <= H_SEND;
            row_q      <= '0;
            col_q      <= '0;
            r_q        <= '0;
            c_q        <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            dig_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
`ifdef MATRIX_PRINTER_SIGNED_EN
            mag_q      <= '0;
            neg_q      <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bad_dim_c) begin
                            err_q <= 1'b1;
                        end else begin
                            for (int k = 0; k < int'(N_ELEM); k++) begin
                                elem_q[k] <= bus.data_flat[k*DATA_W +: DATA_W];
                            end
                            row_q   <= bus.row;
                            col_q   <= bus.col;
                            r_q     <= '0;
                            c_q     <= '0;
                            cnt_q   <= '0;
                            bcd_q   <= '0;
                            hs_q    <= H_SEND;
                            busy_q  <= 1'b1;
                            state_q <= CONV_ENTRY;
                        end
                    end
                end
`ifdef MATRIX_PRINTER_SIGNED_EN
                S_NEG: begin
                    neg_q   <= elem_c[DATA_W-1];
                    mag_q   <= elem_c[DATA_W-1] ? (DATA_W'(0) - elem_c) : elem_c;
                    state_q <= S_CONV;
                end
`endif
                S_CONV: begin
                    bcd_q <= bcd_nxt_c;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        dig_q <= lead_c;
`ifdef MATRIX_PRINTER_SIGNED_EN
                        state_q <= neg_q ? S_MINUS : S_EMIT;
`else
                        state_q <= S_EMIT;
`endif
                    end
                end
                S_MINUS, S_EMIT, S_SEP, S_LF: begin
                    case (hs_q)
                        H_SEND: begin
                            if (!bus.tx_busy) begin
                                tx_start_q <= 1'b1;
                                tx_data_q  <= byte_c;
                                hs_q       <= H_STROBE;
                            end
                        end
                        H_STROBE: hs_q <= H_GUARD;
                        H_GUARD:  hs_q <= H_WAIT;
                        default: begin
                            if (!bus.tx_busy) begin
                                hs_q <= H_SEND;
                                case (state_q)
                                    S_MINUS: state_q <= S_EMIT;
                                    S_EMIT: begin
                                        if (dig_q == '0) state_q <= S_SEP;
                                        else             dig_q   <= dig_q - DIG_W'(1);
                                    end
                                    S_SEP: begin
                                        if (last_col_c) begin
                                            state_q <= S_LF;
                                        end else begin
                                            c_q     <= c_q + DIM_W'(1);
                                            cnt_q   <= '0;
                                            bcd_q   <= '0;
                                            state_q <= CONV_ENTRY;
                                        end
                                    end
                                    default: begin
                                        c_q <= '0;
                                        if (last_row_c) begin
                                            busy_q  <= 1'b0;
                                            done_q  <= 1'b1;
                                            state_q <= S_DONE;
                                        end else begin
                                            r_q     <= r_q + DIM_W'(1);
                                            cnt_q   <= '0;
                                            bcd_q   <= '0;
                                            state_q <= CONV_ENTRY;
                                        end
                                    end
                                endcase
                            end
                        end
                    endcase
                end
                S_DONE: state_q <= S_WAIT_REL;
                S_WAIT_REL: begin
                    if (!bus.start) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_uart_printer.sv
// Directed self-checking bench for matrix_uart_printer with a simple UART busy model.
module tb_matrix_uart_printer;
    localparam int DW   = 8;
    localparam int MD   = 5;
    localparam int DIMW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    matrix_uart_printer_if #(.DATA_W(DW), .MAX_DIM(MD), .DIM_W(DIMW)) bus_if ();

    matrix_uart_printer #(.DATA_W(DW), .MAX_DIM(MD), .DIM_W(DIMW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // UART model: records strobed bytes, busy for busy_len cycles, optionally one cycle late
    logic [7:0] rx_q [$];
    int  busy_len = 10;
    bit  late     = 1'b0;
    bit  hold     = 1'b0;
    int  busy_cnt = 0;
    bit  pend     = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
            pend     <= 1'b0;
        end else if (bus_if.tx_start) begin
            rx_q.push_back(bus_if.tx_data);
            if (late) pend <= 1'b1;
            else      busy_cnt <= busy_len;
        end else if (pend) begin
            pend     <= 1'b0;
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign bus_if.tx_busy = hold || (busy_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic load(input int k, input int v);
        bus_if.data_flat[k*DW +: DW] = DW'(v);
    endtask

    // Pulses start for one edge; returns at the negedge following that edge
    task automatic pulse_start(input int nr, input int nc);
        @(negedge clk);
        bus_if.row   = DIMW'(nr);
        bus_if.col   = DIMW'(nc);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " busy"}, 32'(bus_if.busy), 0);
        chk({tag, " done"}, 32'(bus_if.done), 0);
        chk({tag, " err"}, 32'(bus_if.err), 0);
        chk({tag, " tx_start"}, 32'(bus_if.tx_start), 0);
        chk({tag, " tx_data"}, 32'(bus_if.tx_data), 0);
    endtask

    // Waits for done, checks single pulse, busy low, and the received byte stream
    task automatic finish_print(input string tag, input string exp_s);
        int  n  = 0;
        int  nd = 0;
        logic b = 1'b1;
        while (nd == 0 && n < 5000) begin
            @(negedge clk);
            n++;
            if (bus_if.done) begin
                nd++;
                b = bus_if.busy;
            end
        end
        chk({tag, " done_seen"}, 32'(nd), 1);
        chk({tag, " busy_at_done"}, 32'(b), 0);
        repeat (5) begin
            @(negedge clk);
            if (bus_if.done) nd++;
        end
        chk({tag, " done_once"}, 32'(nd), 1);
        chk({tag, " len"}, 32'(rx_q.size()), 32'(exp_s.len()));
        for (int i = 0; i < exp_s.len(); i++) begin
            chk($sformatf("%s byte%0d", tag, i),
                (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF, 32'(exp_s[i]));
        end
    endtask

    initial begin
        int n;
        int cnt;
        string exp_s;

        bus_if.start     = 1'b0;
        bus_if.row       = '0;
        bus_if.col       = '0;
        bus_if.data_flat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // 2x3 main pattern with latency check
        load(0, 1); load(1, 2); load(2, 3); load(3, 10); load(4, 200); load(5, 0);
        rx_q.delete();
        pulse_start(2, 3);
        chk("busy_after_start", 32'(bus_if.busy), 1);
        n = 0;
        while (!bus_if.tx_start && n < 100) begin
            @(negedge clk);
            n++;
        end
`ifdef MATRIX_PRINTER_SIGNED_EN
        chk("first_tx_latency", 32'(n), 32'(DW + 2));
        exp_s = "1 2 3\r\n10 -56 0\r\n";
`else
        chk("first_tx_latency", 32'(n), 32'(DW + 1));
        exp_s = "1 2 3\r\n10 200 0\r\n";
`endif
        chk("first_tx_data", 32'(bus_if.tx_data), 32'h31);
        finish_print("m2x3", exp_s);

        // Zero row rejected
        pulse_start(0, 3);
        chk("err_row0", 32'(bus_if.err), 1);
        chk("err_row0_busy", 32'(bus_if.busy), 0);
        @(negedge clk);
        chk("err_row0_pulse", 32'(bus_if.err), 0);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus_if.tx_start || bus_if.busy) cnt++;
        end
        chk("err_row0_quiet", 32'(cnt), 0);

        // Oversized dimensions rejected
        pulse_start(6, 1);
        chk("err_row6", 32'(bus_if.err), 1);
        pulse_start(1, 6);
        chk("err_col6", 32'(bus_if.err), 1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.tx_start) cnt++;
        end
        chk("err_dim_quiet", 32'(cnt), 0);

        // Full-width row at MAX_DIM columns
        load(0, 0); load(1, 9); load(2, 10); load(3, 99); load(4, 100);
        rx_q.delete();
        pulse_start(1, 5);
        finish_print("row5", "0 9 10 99 100\r\n");

        // MAX_DIM rows, single column
        load(0, 1); load(1, 2); load(2, 3); load(3, 4); load(4, 5);
        rx_q.delete();
        pulse_start(5, 1);
        finish_print("col1", "1\r\n2\r\n3\r\n4\r\n5\r\n");

        // Top-bit values
        load(0, 255);
        rx_q.delete();
        pulse_start(1, 1);
`ifdef MATRIX_PRINTER_SIGNED_EN
        finish_print("ff", "-1\r\n");
`else
        finish_print("ff", "255\r\n");
`endif
        load(0, 128);
        rx_q.delete();
        pulse_start(1, 1);
`ifdef MATRIX_PRINTER_SIGNED_EN
        finish_print("80", "-128\r\n");
`else
        finish_print("80", "128\r\n");
`endif

        // UART stalled for 100 cycles after the first byte
        load(0, 4); load(1, 5);
        rx_q.delete();
        pulse_start(1, 2);
        n = 0;
        while (!bus_if.tx_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        hold = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_if.tx_start) cnt++;
        end
        chk("hold_no_strobe", 32'(cnt), 0);
        chk("hold_rx_count", 32'(rx_q.size()), 1);
        hold = 1'b0;
        finish_print("hold", "4 5\r\n");

        // UART raising busy one cycle late
        late = 1'b1;
        busy_len = 3;
        load(0, 11); load(1, 22); load(2, 33); load(3, 44);
        rx_q.delete();
        pulse_start(2, 2);
        finish_print("late", "11 22\r\n33 44\r\n");
        late = 1'b0;
        busy_len = 10;

        // Reset during the second row
        load(0, 1); load(1, 2); load(2, 3); load(3, 10); load(4, 200); load(5, 0);
        rx_q.delete();
        pulse_start(2, 3);
        n = 0;
        while (rx_q.size() < 9 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rst_reached_row2", 32'(rx_q.size() >= 9), 1);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx_start", 32'(bus_if.tx_start), 0);
        chk("post_rst_busy", 32'(bus_if.busy), 0);

        // Fresh 1x1 print with start toggled while busy
        load(0, 7);
        rx_q.delete();
        pulse_start(1, 1);
        repeat (3) @(negedge clk);
        bus_if.row   = 3'd2;
        bus_if.col   = 3'd2;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (20) @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        finish_print("fresh7", "7\r\n");

        // Start held through done must not retrigger until released
        load(0, 3);
        rx_q.delete();
        @(negedge clk);
        bus_if.row   = 3'd1;
        bus_if.col   = 3'd1;
        bus_if.start = 1'b1;
        finish_print("held", "3\r\n");
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.busy || bus_if.tx_start) cnt++;
        end
        chk("held_no_restart", 32'(cnt), 0);
        bus_if.start = 1'b0;
        @(negedge clk);
        rx_q.delete();
        pulse_start(1, 1);
        chk("release_restart_busy", 32'(bus_if.busy), 1);
        finish_print("rel", "3\r\n");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
